std_fp_mult_seq_4_2_2: RTL and testbench
========================================

Name: std_fp_mult_seq_4_2_2

Overview:
Sequential unsigned fixed-point shift-add multiplier; the multiply counterpart to the team's sequential fixed-point divider. It uses the same go/done handshake and the same Q(INT_WIDTH).(FRAC_WIDTH) operand format. It sits in the generated-primitive library and is instantiated by compiled control logic wherever a multi-cycle fixed-point multiply is cheaper than a combinational one.

Parameters:
WIDTH, 4, total operand/result width in bits
INT_WIDTH, 2, integer bits of operands and result
FRAC_WIDTH, 2, fractional bits of operands and result (INT_WIDTH + FRAC_WIDTH == WIDTH)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
go  input  1  request; must stay high until done
left  input  WIDTH  multiplicand, unsigned fixed-point
right  input  WIDTH  multiplier, unsigned fixed-point
out_product  output  WIDTH  result bits [WIDTH+FRAC_WIDTH-1:FRAC_WIDTH] of the 2*WIDTH raw product
out_overflow  output  1  high if any raw product bit above WIDTH+FRAC_WIDTH-1 is set
done  output  1  single-cycle completion pulse

Behaviour:
- Internal state:
  - running flag.
  - idx counter, $clog2(WIDTH) bits.
  - acc, 2*WIDTH bits.
  - mcand, 2*WIDTH bits.
  - mplier, WIDTH bits.
- Reset (all registers): running=0, idx=0, acc=0, mcand=0, mplier=0, out_product=0, out_overflow=0, done=0.
- start = go && !running.
- zero_op = start && (left==0 || right==0).
- finished = running && idx==WIDTH-1.
- States are IDLE (running=0) and RUN (running=1).
- IDLE, start and not zero_op:
  - acc<=0.
  - mcand<={WIDTH zeros, left}.
  - mplier<=right.
  - idx<=0.
  - running<=1.
- IDLE, zero_op:
  - running stays 0.
  - out_product<=0, out_overflow<=0.
  - done<=1 on that edge.
- RUN, each edge:
  - acc<=acc_next, where acc_next = acc + (mplier[0] ? mcand : 0), computed mod 2^(2*WIDTH).
  - mcand<=mcand<<1.
  - mplier<=mplier>>1.
  - idx<=idx+1.
- RUN, finished edge:
  - out_product<=acc_next[WIDTH+FRAC_WIDTH-1:FRAC_WIDTH].
  - out_overflow<=|acc_next[2*WIDTH-1:WIDTH+FRAC_WIDTH].
  - done<=1.
  - running<=0, idx<=0.
- Latency: with start sampled at edge E0, done is high in the cycle after edge E_WIDTH, i.e. WIDTH cycles after the start edge. Zero operands give 1 cycle.
- done is high for exactly one cycle per completed operation and low otherwise.
- out_product and out_overflow hold their values until the next completion, zero_op, or reset. They are not cleared at start.
- go low while running is an abort:
  - running<=0, idx<=0.
  - No done pulse.
  - Outputs keep their prior values.
- go held high after done: a new start occurs in the cycle after the finished edge, using the current left/right.
- Reset mid-operation: returns to IDLE with all reset values and no done. Reset has priority over start, finished and abort.
- Operands are sampled only at start; changes to left/right during RUN have no effect.

Optional Feature:
- Macro: STD_FP_MULT_ROUND_EN.
- Defined: round-half-up.
  - out_product = acc_next[WIDTH+FRAC_WIDTH-1:FRAC_WIDTH] + acc_next[FRAC_WIDTH-1], mod 2^WIDTH.
  - out_overflow additionally sets if that increment carries out of WIDTH bits.
  - Applies only when FRAC_WIDTH>0.
- Undefined: plain truncation, as described in Behaviour.
- Latency is identical in both builds.

Test Plan:
- Basic product: left=4'b0110 (1.5), right=4'b0101 (1.25), go held -> done 4 cycles after the start edge, out_product=4'b0111, out_overflow=0. With STD_FP_MULT_ROUND_EN: out_product=4'b1000.
- Overflow: left=4'b1111, right=4'b1000 -> raw product 8'h78, out_product=4'b1110, out_overflow=1. Same result with rounding enabled.
- Zero operand: left=0, right=4'b1011, go=1 -> done 1 cycle after the start edge, out_product=0, out_overflow=0, running never set.
- Back-to-back: go held high through two operations, (2.0*1.0) then (0.25*0.25):
  - First result: out_product=4'b1000.
  - Second result: out_product=4'b0000 (raw 1); out_product=4'b0000 with rounding.
  - Done pulses are one cycle wide, separated by 4 cycles (each operation takes 4 cycles).
- Abort: go dropped 2 cycles into RUN -> no done, out_product keeps its previous value; a new go then completes normally in 4 cycles.
- Reset mid-RUN: reset=1 at cycle 2 -> next cycle all outputs 0, done=0; the following go completes normally.

Source files
------------

// File: rtl/std_fp_mult_seq_4_2_2.sv
// Sequential unsigned fixed-point shift-add multiplier, Q(INT_WIDTH).(FRAC_WIDTH), go/done handshake.
// Define STD_FP_MULT_ROUND_EN for round-half-up on the discarded fraction; otherwise truncates.
module std_fp_mult_seq_4_2_2 #(
  parameter int WIDTH      = 4,
  parameter int INT_WIDTH  = 2,
  parameter int FRAC_WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_product,
  output logic             out_overflow,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW    = 2 * WIDTH;
  localparam int HI_LSB = AW - INT_WIDTH;  // first raw bit above the result window

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [AW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   out_product_q, out_product_d;
  logic               out_overflow_q, out_overflow_d;
  logic               done_q, done_d;

  logic               running, start, zero_op, finished;
  logic [AW-1:0]      acc_next;
  logic [WIDTH-1:0]   res_trunc, res_prod;
  logic               ovf_hi, res_ovf;

  assign running  = (state_q == RUN);
  assign start    = go && !running;
  assign zero_op  = start && ((left == '0) || (right == '0));
  assign finished = running && (idx_q == IDX_W'(WIDTH - 1));

  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign res_trunc = WIDTH'(acc_next >> FRAC_WIDTH);
  assign ovf_hi    = |(acc_next >> HI_LSB);

`ifdef STD_FP_MULT_ROUND_EN
  generate
    if (FRAC_WIDTH > 0) begin : g_round
      localparam int RW = WIDTH + 1;
      logic [WIDTH:0] rsum;
      // Carry out of the increment is folded into overflow.
      assign rsum     = {1'b0, res_trunc} + RW'(acc_next[FRAC_WIDTH-1]);
      assign res_prod = rsum[WIDTH-1:0];
      assign res_ovf  = ovf_hi | rsum[WIDTH];
    end else begin : g_noround
      assign res_prod = res_trunc;
      assign res_ovf  = ovf_hi;
    end
  endgenerate
`else
  assign res_prod = res_trunc;
  assign res_ovf  = ovf_hi;
`endif

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    acc_d          = acc_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    out_product_d  = out_product_q;
    out_overflow_d = out_overflow_q;
    done_d         = 1'b0;

    if (!running) begin
      if (zero_op) begin
        out_product_d  = '0;
        out_overflow_d = 1'b0;
        done_d         = 1'b1;
      end else if (start) begin
        acc_d    = '0;
        mcand_d  = AW'(left);
        mplier_d = right;
        idx_d    = '0;
        state_d  = RUN;
      end
    end else if (!go) begin
      // Abort: drop back to idle silently, results untouched.
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      idx_d    = idx_q + IDX_W'(1);
      if (finished) begin
        out_product_d  = res_prod;
        out_overflow_d = res_ovf;
        done_d         = 1'b1;
        state_d        = IDLE;
        idx_d          = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      acc_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      out_product_q  <= '0;
      out_overflow_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      out_product_q  <= out_product_d;
      out_overflow_q <= out_overflow_d;
      done_q         <= done_d;
    end
  end

  assign out_product  = out_product_q;
  assign out_overflow = out_overflow_q;
  assign done         = done_q;

endmodule

// File: tb/tb_std_fp_mult_seq_4_2_2.sv
// Scoreboard bench for std_fp_mult_seq_4_2_2: expected result and completion cycle queued at go.
module tb_std_fp_mult_seq_4_2_2;

  logic       clk = 1'b0;
  logic       reset, go;
  logic [3:0] left, right;
  logic [3:0] out_product;
  logic       out_overflow, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [3:0] prod;
    logic       ovf;
    int         due;
  } exp_t;

  exp_t sb[$];

`ifdef STD_FP_MULT_ROUND_EN
  localparam logic [3:0] BASIC_EXP = 4'b1000;
`else
  localparam logic [3:0] BASIC_EXP = 4'b0111;
`endif

  std_fp_mult_seq_4_2_2 #(.WIDTH(4), .INT_WIDTH(2), .FRAC_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
    .out_product(out_product), .out_overflow(out_overflow), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [3:0] l, input logic [3:0] r, input int due);
    exp_t e;
    logic [7:0] raw;
    logic [4:0] s;
    raw = {4'b0, l} * {4'b0, r};
`ifdef STD_FP_MULT_ROUND_EN
    s = {1'b0, raw[5:2]} + {4'b0, raw[1]};
    e.prod = s[3:0];
    e.ovf  = (raw[7:6] != 2'b00) || s[4];
`else
    e.prod = raw[5:2];
    e.ovf  = (raw[7:6] != 2'b00);
`endif
    e.due = due;
    return e;
  endfunction

  // Scoreboard: every done pops one expectation and checks value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done cyc=%0d got done=1 required done=0", cyc);
      end else begin
        e = sb.pop_front();
        if (out_product !== e.prod || out_overflow !== e.ovf) begin
          n_fail++;
          $display("FAIL result cyc=%0d got prod=%b ovf=%b required prod=%b ovf=%b",
                   cyc, out_product, out_overflow, e.prod, e.ovf);
        end
        n_tests++;
        if (cyc !== e.due) begin
          n_fail++;
          $display("FAIL latency got done at cyc=%0d required cyc=%0d", cyc, e.due);
        end
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing_done cyc=%0d required done at cyc=%0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  // Drive one operation from a negedge, hold go until done, then drop it.
  task automatic run_op(input logic [3:0] l, input logic [3:0] r);
    bit seen = 0;
    int c;
    left = l; right = r; go = 1'b1;
    c = cyc;
    sb.push_back(model(l, r, c + (((l == 0) || (r == 0)) ? 1 : 5)));
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    go = 1'b0;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout op %b*%b got no done required done", l, r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; left = '0; right = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_product !== 4'b0 || out_overflow !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got prod=%b ovf=%b done=%b required 0000/0/0",
               out_product, out_overflow, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op(4'b0110, 4'b0101);
    n_tests++;
    if (out_product !== BASIC_EXP || out_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL basic got prod=%b ovf=%b required prod=%b ovf=0", out_product, out_overflow, BASIC_EXP);
    end
  endtask

  task automatic test_overflow();
    run_op(4'b1111, 4'b1000);
    n_tests++;
    if (out_product !== 4'b1110 || out_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow got prod=%b ovf=%b required prod=1110 ovf=1", out_product, out_overflow);
    end
  endtask

  task automatic test_zero();
    run_op(4'b0000, 4'b1011);
    n_tests++;
    if (out_product !== 4'b0 || out_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_op got prod=%b ovf=%b required prod=0000 ovf=0", out_product, out_overflow);
    end
    run_op(4'b0111, 4'b0000);
  endtask

  task automatic test_back_to_back();
    int c, ndone;
    left = 4'b1000; right = 4'b0100; go = 1'b1;
    c = cyc;
    sb.push_back(model(4'b1000, 4'b0100, c + 5));
    sb.push_back(model(4'b0001, 4'b0001, c + 10));
    ndone = 0;
    for (int i = 0; i < 16 && ndone < 2; i++) begin
      @(negedge clk);
      if (i == 1) begin left = 4'b0001; right = 4'b0001; end  // mid-RUN change must not matter
      if (done) begin
        ndone++;
        n_tests++;
        if (ndone == 1 && out_product !== 4'b1000) begin
          n_fail++;
          $display("FAIL b2b_first got prod=%b required prod=1000", out_product);
        end
        if (ndone == 2 && out_product !== 4'b0000) begin
          n_fail++;
          $display("FAIL b2b_second got prod=%b required prod=0000", out_product);
        end
      end
    end
    go = 1'b0;
    n_tests++;
    if (ndone != 2) begin
      n_fail++;
      $display("FAIL b2b_count got %0d done pulses required 2", ndone);
    end
  endtask

  task automatic test_abort();
    logic [3:0] prev_p;
    logic       prev_o;
    run_op(4'b1101, 4'b1110);
    prev_p = out_product; prev_o = out_overflow;
    left = 4'b0111; right = 4'b0011; go = 1'b1;
    repeat (2) @(negedge clk);
    go = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (out_product !== prev_p || out_overflow !== prev_o) begin
      n_fail++;
      $display("FAIL abort_hold got prod=%b ovf=%b required prod=%b ovf=%b",
               out_product, out_overflow, prev_p, prev_o);
    end
    run_op(4'b0011, 4'b0011);
  endtask

  task automatic test_reset_mid();
    left = 4'b0101; right = 4'b0110; go = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1; go = 1'b0;
    sb.delete();
    @(negedge clk);
    n_tests++;
    if (out_product !== 4'b0 || out_overflow !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got prod=%b ovf=%b done=%b required 0000/0/0",
               out_product, out_overflow, done);
    end
    reset = 1'b0;
    @(negedge clk);
    run_op(4'b0010, 4'b0011);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (i[0]) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    repeat (6) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish");
    $fatal(1, "watchdog");
  end

endmodule
